// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM SPI command driver and its receive-side capture block.
package psram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSkip,
    StData,
    StDrain
  } rx_state_e;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam logic [7:0] CMD_RDID   = 8'h9F;

  localparam int unsigned READ_SKIP_BITS = 32;
  localparam int unsigned RDID_SKIP_BITS = 32;

endpackage

// File: rtl/psram_rx_capture_if.sv
// Byte stream from the capture FIFO to its consumer (valid/ready).
interface psram_rx_capture_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/psram_rx_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a same-cycle push when full.
module psram_rx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wptr_q[Aw-1:0]] <= data_i;
  end

endmodule

// File: rtl/psram_rx_capture.sv
// Samples PSRAM MISO on each SCK edge, skips command/address bits and buffers read bytes MSB-first.
module psram_rx_capture
  import psram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned SKIP_W     = 6
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              start,
  input  logic [SKIP_W-1:0] skip_bits,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic              ce_n,
  input  logic              miso,
  psram_rx_capture_if.master rd,
  output logic              busy,
  output logic              done,
  output logic              short_err,
  output logic              overflow,
  input  logic              clr_flags
);

  rx_state_e         state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d, skip_cnt_q, skip_cnt_d, skip_next;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d, byte_next;
  logic              done_q, done_d, short_q, short_d, ovf_q, ovf_d;
  logic              skip_edge, data_edge, push, set_short, set_ovf;
  logic              fifo_full, fifo_empty, pop;

  assign skip_next = skip_cnt_q + 1'b1;
  assign byte_next = {shift_q[6:0], miso};

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    skip_cnt_d = skip_cnt_q;
    len_d      = len_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    push       = 1'b0;
    set_short  = 1'b0;
    skip_edge  = 1'b0;
    data_edge  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          skip_d     = skip_bits;
          len_d      = byte_count;
          skip_cnt_d = '0;
          bit_idx_d  = '0;
          shift_d    = '0;
          state_d    = StArmed;
        end
      end
      StArmed: begin
        if (!ce_n) begin
          if (skip_q == '0) data_edge = 1'b1;
          else              skip_edge = 1'b1;
        end
      end
      StSkip, StData: begin
        if (ce_n) begin
          // Early chip-select release; the partial byte is simply abandoned.
          done_d    = 1'b1;
          set_short = (len_q != '0);
          state_d   = StIdle;
        end else if (state_q == StSkip) begin
          skip_edge = 1'b1;
        end else begin
          data_edge = 1'b1;
        end
      end
      StDrain: begin
        if (ce_n) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (skip_edge) begin
      skip_cnt_d = skip_next;
      if (skip_next == skip_q) state_d = (len_q == '0) ? StDrain : StData;
      else                     state_d = StSkip;
    end

    if (data_edge) begin
      if (len_q == '0) begin
        state_d = StDrain;
      end else begin
        shift_d   = byte_next;
        bit_idx_d = bit_idx_q + 3'd1;
        state_d   = StData;
        if (bit_idx_q == 3'd7) begin
          push  = 1'b1;
          len_d = len_q - 1'b1;
          if (len_q == LEN_W'(1)) state_d = StDrain;
        end
      end
    end
  end

  assign pop     = rd.rd_valid && rd.rd_ready;
  assign set_ovf = push && fifo_full && !pop;

  // Clear takes priority over a same-cycle set.
  always_comb begin
    short_d = clr_flags ? 1'b0 : (short_q | set_short);
    ovf_d   = clr_flags ? 1'b0 : (ovf_q | set_ovf);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= StIdle;
      skip_q     <= '0;
      skip_cnt_q <= '0;
      len_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      skip_cnt_q <= skip_cnt_d;
      len_q      <= len_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      short_q    <= short_d;
      ovf_q      <= ovf_d;
    end
  end

  psram_rx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .push_i      (push),
    .data_i      (byte_next),
    .pop_i       (rd.rd_ready),
    .data_o      (rd.rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd.rd_valid = !fifo_empty;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign short_err   = short_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_psram_rx_capture.sv
// Randomized bench for psram_rx_capture against a bit-position/queue reference model.
module tb_psram_rx_capture;

  localparam int DEPTH = 4;
  localparam int LW    = 8;
  localparam int SW    = 6;

  logic          sys_clk     = 1'b0;
  logic          sys_reset_n = 1'b0;
  logic          start       = 1'b0;
  logic [SW-1:0] skip_bits   = '0;
  logic [LW-1:0] byte_count  = '0;
  logic          ce_n        = 1'b1;
  logic          miso        = 1'b0;
  logic          clr_flags   = 1'b0;
  logic          busy, done, short_err, overflow;

  psram_rx_capture_if rd_if ();

  psram_rx_capture #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW),
    .SKIP_W     (SW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .start       (start),
    .skip_bits   (skip_bits),
    .byte_count  (byte_count),
    .ce_n        (ce_n),
    .miso        (miso),
    .rd          (rd_if),
    .busy        (busy),
    .done        (done),
    .short_err   (short_err),
    .overflow    (overflow),
    .clr_flags   (clr_flags)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: data bit position derived from the SCK edge count of the transaction.
  logic [7:0] m_q[$];
  logic [7:0] rx_log[$];
  bit         m_txn = 0;
  int         m_skip, m_cnt, m_edges, m_bytes, m_d;
  logic [7:0] m_cur;
  bit         m_done = 0, m_short = 0, m_ovf = 0;
  bit         m_pop, m_push, m_set_s, m_set_o;
  bit         chk_en = 0;
  int         done_seen = 0;
  bit         tx_bits[$];

  initial begin
    forever begin
      @(posedge sys_clk);
      if (!sys_reset_n) begin
        m_q.delete();
        m_txn = 0; m_done = 0; m_short = 0; m_ovf = 0;
        m_edges = 0; m_bytes = 0; m_cur = '0;
      end else begin
        if (rd_if.rd_valid && rd_if.rd_ready) rx_log.push_back(rd_if.rd_data);
        m_pop = (m_q.size() > 0) && rd_if.rd_ready;
        m_push = 0; m_set_s = 0; m_set_o = 0; m_done = 0;
        if (!m_txn) begin
          if (start) begin
            m_txn = 1; m_skip = int'(skip_bits); m_cnt = int'(byte_count);
            m_edges = 0; m_bytes = 0;
          end
        end else if (!ce_n) begin
          m_edges++;
          m_d = m_edges - m_skip - 1;
          if (m_d >= 0 && m_d < 8 * m_cnt) begin
            m_cur = {m_cur[6:0], miso};
            if (m_d % 8 == 7) begin m_push = 1; m_bytes++; end
          end
        end else if (m_edges > 0) begin
          m_done = 1; m_set_s = (m_bytes < m_cnt); m_txn = 0;
        end
        if (m_pop) void'(m_q.pop_front());
        if (m_push) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_cur);
          else m_set_o = 1;
        end
        if (clr_flags) begin m_short = 0; m_ovf = 0; end
        else begin m_short = m_short | m_set_s; m_ovf = m_ovf | m_set_o; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_reset_n && chk_en) begin
        check("rd_valid", 32'(rd_if.rd_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("rd_data", 32'(rd_if.rd_data), 32'(m_q[0]));
        check("busy", 32'(busy), 32'(m_txn));
        check("done", 32'(done), 32'(m_done));
        check("short_err", 32'(short_err), 32'(m_short));
        check("overflow", 32'(overflow), 32'(m_ovf));
      end
      if (sys_reset_n && done === 1'b1) done_seen++;
    end
  end

  // mode: 0 = consumer stalled, 1 = always ready, 2 = random ready and occasional flag clear
  task automatic step(input int mode);
    @(negedge sys_clk);
    #1;
    case (mode)
      0:       rd_if.rd_ready = 1'b0;
      1:       rd_if.rd_ready = 1'b1;
      default: rd_if.rd_ready = ($urandom_range(0, 3) != 0);
    endcase
    clr_flags = (mode == 2) && ($urandom_range(0, 15) == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
  endtask

  task automatic run_txn(input int skip, input int cnt, input int nedges, input int mode,
                         input bit extra_start);
    step(mode);
    skip_bits = SW'(skip); byte_count = LW'(cnt); start = 1'b1;
    step(mode);
    start = 1'b0;
    repeat (2) step(mode);
    for (int i = 0; i < nedges; i++) begin
      step(mode);
      ce_n = 1'b0;
      miso = (i < tx_bits.size()) ? tx_bits[i] : 1'($urandom_range(0, 1));
      start = (extra_start && i == 3) || (mode == 2 && $urandom_range(0, 19) == 0);
      if (start) begin skip_bits = '0; byte_count = LW'(5); end
    end
    step(mode);
    ce_n = 1'b1; start = 1'b0;
    repeat (3) step(mode);
    tx_bits.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) step(1);
  endtask

  task automatic clear_flags();
    step(1); clr_flags = 1'b1;
    step(1); clr_flags = 1'b0;
  endtask

  int d0;
  int rs, rc, rn;

  initial begin
    rd_if.rd_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1 sys_reset_n = 1'b1;
    @(negedge sys_clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(rd_if.rd_valid), 32'h0);
    check("reset_data", 32'(rd_if.rd_data), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_flags", 32'({short_err, overflow}), 32'h0);
    chk_en = 1;

    // Single-byte read behind a 32-bit command/address header.
    rx_log.delete(); d0 = done_seen;
    push_byte(8'h03); push_byte(8'h70); push_byte(8'hF0); push_byte(8'hFE); push_byte(8'h66);
    run_txn(32, 1, 40, 1, 0);
    drain(3);
    check("single_count", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() > 0) check("single_byte", 32'(rx_log[0]), 32'h66);
    check("single_done", 32'(done_seen - d0), 32'd1);
    check("single_flags", 32'({short_err, overflow}), 32'h0);

    // Read-ID burst.
    rx_log.delete(); d0 = done_seen;
    repeat (4) push_byte(8'h00);
    push_byte(8'h0D); push_byte(8'h5D); push_byte(8'h52);
    run_txn(32, 3, 56, 1, 0);
    drain(3);
    check("rdid_count", 32'(rx_log.size()), 32'd3);
    if (rx_log.size() == 3) begin
      check("rdid_b0", 32'(rx_log[0]), 32'h0D);
      check("rdid_b1", 32'(rx_log[1]), 32'h5D);
      check("rdid_b2", 32'(rx_log[2]), 32'h52);
    end
    check("rdid_done", 32'(done_seen - d0), 32'd1);

    // Overflow with a stalled consumer.
    rx_log.delete(); d0 = done_seen;
    repeat (4) push_byte(8'hFF);
    for (int i = 1; i <= 6; i++) push_byte(8'hA0 + 8'(i));
    run_txn(32, 6, 82, 0, 0);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_done", 32'(done_seen - d0), 32'd1);
    drain(6);
    check("ovf_count", 32'(rx_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_log.size(); i++)
      check("ovf_byte", 32'(rx_log[i]), 32'(8'hA1 + 8'(i)));
    clear_flags();
    step(1);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Short transaction: chip-select released 4 bits into the second byte.
    rx_log.delete(); d0 = done_seen;
    repeat (4) push_byte(8'h00);
    push_byte(8'hB7); push_byte(8'hC8);
    run_txn(32, 2, 44, 1, 0);
    drain(2);
    check("short_count", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() > 0) check("short_byte", 32'(rx_log[0]), 32'hB7);
    check("short_flag", 32'(short_err), 32'h1);
    check("short_done", 32'(done_seen - d0), 32'd1);
    check("short_idle", 32'(busy), 32'h0);
    clear_flags();

    // Reset mid-DATA with one byte already buffered.
    d0 = done_seen;
    step(0);
    skip_bits = SW'(8); byte_count = LW'(4); start = 1'b1;
    step(0); start = 1'b0;
    for (int i = 0; i < 20; i++) begin step(0); ce_n = 1'b0; miso = 1'(i % 3); end
    step(0); sys_reset_n = 1'b0;
    step(0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(rd_if.rd_valid), 32'h0);
    sys_reset_n = 1'b1;
    step(0); ce_n = 1'b1;
    repeat (3) step(0);
    check("rst_no_done", 32'(done_seen - d0), 32'd0);

    // Zero-length transaction.
    rx_log.delete(); d0 = done_seen;
    run_txn(8, 0, 10, 1, 0);
    check("zero_count", 32'(rx_log.size()), 32'd0);
    check("zero_done", 32'(done_seen - d0), 32'd1);
    check("zero_short", 32'(short_err), 32'h0);

    // start while busy must be ignored.
    rx_log.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h5A);
    run_txn(16, 1, 24, 1, 1);
    drain(2);
    check("busy_start_count", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() > 0) check("busy_start_byte", 32'(rx_log[0]), 32'h5A);

    // Randomized transactions: random lengths, early/late release, random backpressure.
    for (int t = 0; t < 40; t++) begin
      rs = $urandom_range(0, 40);
      rc = $urandom_range(0, 7);
      rn = rs + 8 * rc + $urandom_range(0, 14) - 10;
      if (rn < 1) rn = 1;
      run_txn(rs, rc, rn, 2, 0);
    end
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
